// File: rtl/timer_pkg.sv
// Shared definitions for the sequential timer and the interval meter.
package timer_pkg;

  localparam int TMR_WIDTH = 16;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_MEAS = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/interval_meter_sat_counter.sv
// WIDTH-bit up counter that sticks at its maximum; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  // Count register: clear, or increment while below the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == CNT_MAX);

endmodule

// File: rtl/interval_meter.sv
// Start-to-stop cycle meter: FSM, result registers and valid/ready handshake.
module interval_meter
  import timer_pkg::*;
#(
  parameter int WIDTH = TMR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] meas_o,
  output logic             ovf_o,
  output logic             miss_o
);

  tmr_state_e       r_state;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_meas;
  logic             r_ovf_out;
  logic             r_miss;
  logic             r_ovf;
  logic             w_clr;
  logic             w_inc;
  logic             w_sat;
  logic [WIDTH-1:0] w_count;

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_count(w_count),
    .o_sat  (w_sat)
  );

  // Counter control: clear on every (re-)arm, count only while measuring.
  always_comb begin
    w_clr = 1'b0;
    w_inc = 1'b0;
    case (r_state)
      TMR_IDLE: w_clr = start_i;
      TMR_MEAS: begin
        if (stop_i) begin
          w_inc = 1'b0;
        end else if (start_i) begin
          w_clr = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      TMR_DONE: w_clr = start_i & res_ready_i;
      default: begin
        w_clr = 1'b0;
        w_inc = 1'b0;
      end
    endcase
  end

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= TMR_IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_meas    <= {WIDTH{1'b0}};
      r_ovf_out <= 1'b0;
      r_miss    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        TMR_IDLE: begin
          if (start_i) begin
            r_state <= TMR_MEAS;
            r_busy  <= 1'b1;
            r_ovf   <= 1'b0;
          end
        end
        TMR_MEAS: begin
          if (stop_i) begin
            r_meas    <= w_count;
            r_ovf_out <= r_ovf;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= TMR_DONE;
          end else if (start_i) begin
            r_ovf <= 1'b0;
          end else if (w_sat) begin
            // an increment attempted at the maximum means the interval no longer fits
            r_ovf <= 1'b1;
          end
        end
        TMR_DONE: begin
          if (res_ready_i) begin
            r_valid <= 1'b0;
            if (start_i) begin
              r_state <= TMR_MEAS;
              r_busy  <= 1'b1;
              r_ovf   <= 1'b0;
            end else begin
              r_state <= TMR_IDLE;
            end
          end else if (start_i) begin
            r_miss <= 1'b1;
          end
        end
        default: begin
          r_state <= TMR_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign res_valid_o = r_valid;
  assign meas_o      = r_meas;
  assign ovf_o       = r_ovf_out;
  assign miss_o      = r_miss;

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter: 16-bit instance plus a 4-bit instance for saturation.
module tb_interval_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_start = 1'b0, a_stop = 1'b0, a_ready = 1'b1;
  logic        a_busy, a_valid, a_ovf, a_miss;
  logic [15:0] a_meas;
  logic        b_start = 1'b0, b_stop = 1'b0, b_ready = 1'b1;
  logic        b_busy, b_valid, b_ovf, b_miss;
  logic [3:0]  b_meas;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        ovf;
    logic [15:0] meas;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  interval_meter #(.WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .stop_i(a_stop), .busy_o(a_busy),
    .res_valid_o(a_valid), .res_ready_i(a_ready), .meas_o(a_meas), .ovf_o(a_ovf), .miss_o(a_miss)
  );

  interval_meter #(.WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .stop_i(b_stop), .busy_o(b_busy),
    .res_valid_o(b_valid), .res_ready_i(b_ready), .meas_o(b_meas), .ovf_o(b_ovf), .miss_o(b_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start at E0, stop at Ek on instance A
  task automatic measure_a(input int k);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (k - 1) tick();
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (exp_q.size() != 0);
    if (ok) e = exp_q.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    exp_t obs;
    #2;
    n_cmp++;
    if ({a_busy, a_valid, a_meas, a_ovf, a_miss} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_a: got %b, want all zero", {a_busy, a_valid, a_meas, a_ovf, a_miss});
    end
    n_cmp++;
    if ({b_busy, b_valid, b_meas, b_ovf, b_miss} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_b: got %b, want all zero", {b_busy, b_valid, b_meas, b_ovf, b_miss});
    end
    tick();
    rst = 1'b0;
    tick();
    obs = '0;
  endtask

  task automatic test_basic();
    exp_t e;
    bit ok;
    a_ready = 1'b1;
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd4});
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n_cmp++;
    if (a_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b, want 1", a_busy); end
    repeat (4) tick();
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    n_cmp++;
    if ({a_valid, a_busy} !== 2'b10) begin
      n_err++; $display("FAIL basic_valid_busy: got %b, want 10", {a_valid, a_busy});
    end
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || {a_ovf, a_meas} !== {e.ovf, e.meas}) begin
      n_err++; $display("FAIL basic_result: got ovf=%b meas=%0d, want ovf=%b meas=%0d", a_ovf, a_meas, e.ovf, e.meas);
    end
    tick();
    n_cmp++;
    if ({a_valid, a_busy} !== 2'b00) begin
      n_err++; $display("FAIL basic_idle: got %b, want 00", {a_valid, a_busy});
    end
  endtask

  task automatic test_loopback();
    exp_t e;
    bit ok;
    int ns[3] = '{1, 7, 65535};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_t'{ovf: 1'b0, meas: ns[i][15:0]});
      measure_a(ns[i] + 1);
      pop_exp(e, ok);
      n_cmp++;
      if (!ok || a_valid !== 1'b1 || {a_ovf, a_meas} !== {e.ovf, e.meas}) begin
        n_err++;
        $display("FAIL loopback_n%0d: got valid=%b ovf=%b meas=%0d, want valid=1 ovf=%b meas=%0d",
                 ns[i], a_valid, a_ovf, a_meas, e.ovf, e.meas);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    bit ok;
    exp_q.push_back(exp_t'{ovf: 1'b1, meas: 16'd15});
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (19) tick();
    b_stop = 1'b1;
    tick();
    b_stop = 1'b0;
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || b_valid !== 1'b1 || {b_ovf, 12'd0, b_meas} !== {e.ovf, e.meas}) begin
      n_err++;
      $display("FAIL saturate: got valid=%b ovf=%b meas=%0d, want valid=1 ovf=%b meas=%0d",
               b_valid, b_ovf, b_meas, e.ovf, e.meas);
    end
    tick();
  endtask

  task automatic test_rearm();
    exp_t e;
    bit ok;
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd2});
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (2) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (2) tick();
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || a_valid !== 1'b1 || a_meas !== e.meas) begin
      n_err++; $display("FAIL rearm: got valid=%b meas=%0d, want valid=1 meas=%0d", a_valid, a_meas, e.meas);
    end
    tick();
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd3});
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (3) tick();
    a_start = 1'b1; a_stop = 1'b1; tick(); a_start = 1'b0; a_stop = 1'b0;
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || {a_valid, a_busy} !== 2'b10 || a_meas !== e.meas) begin
      n_err++;
      $display("FAIL start_stop_same: got valid=%b busy=%b meas=%0d, want valid=1 busy=0 meas=%0d",
               a_valid, a_busy, a_meas, e.meas);
    end
    tick();
    n_cmp++;
    if ({a_valid, a_busy} !== 2'b00) begin
      n_err++; $display("FAIL start_stop_idle: got %b, want 00", {a_valid, a_busy});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    int misses = 0;
    int unstable = 0;
    a_ready = 1'b0;
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd2});
    measure_a(3);
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || a_valid !== 1'b1 || a_meas !== e.meas) begin
      n_err++; $display("FAIL bp_result: got valid=%b meas=%0d, want valid=1 meas=%0d", a_valid, a_meas, e.meas);
    end
    for (int i = 0; i < 10; i++) begin
      a_start = (i == 3) ? 1'b1 : 1'b0;
      tick();
      if (a_miss === 1'b1) misses++;
      if (a_valid !== 1'b1 || a_meas !== e.meas || a_busy !== 1'b0) unstable++;
    end
    a_start = 1'b0;
    n_cmp++;
    if (misses !== 1) begin n_err++; $display("FAIL bp_miss: got %0d pulses, want 1", misses); end
    n_cmp++;
    if (unstable !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles, want 0", unstable); end
    a_start = 1'b1;
    a_ready = 1'b1;
    tick();
    a_start = 1'b0;
    n_cmp++;
    if ({a_valid, a_busy} !== 2'b01) begin
      n_err++; $display("FAIL bp_restart: got valid,busy=%b, want 01", {a_valid, a_busy});
    end
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd4});
    repeat (4) tick();
    a_stop = 1'b1; tick(); a_stop = 1'b0;
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || a_valid !== 1'b1 || {a_ovf, a_meas} !== {e.ovf, e.meas}) begin
      n_err++; $display("FAIL bp_next: got valid=%b meas=%0d, want valid=1 meas=%0d", a_valid, a_meas, e.meas);
    end
    tick();
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit ok;
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_busy, a_valid, a_meas, a_ovf, a_miss} !== 20'd0) begin
      n_err++; $display("FAIL rst_meas: got %b, want all zero", {a_busy, a_valid, a_meas, a_ovf, a_miss});
    end
    #2;
    tick();
    rst = 1'b0;
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd2});
    measure_a(3);
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || a_valid !== 1'b1 || a_meas !== e.meas) begin
      n_err++; $display("FAIL rst_meas_after: got valid=%b meas=%0d, want valid=1 meas=%0d", a_valid, a_meas, e.meas);
    end
    tick();
    a_ready = 1'b0;
    measure_a(4);
    n_cmp++;
    if ({a_valid, a_meas} !== {1'b1, 16'd3}) begin
      n_err++; $display("FAIL rst_done_pre: got valid=%b meas=%0d, want valid=1 meas=3", a_valid, a_meas);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_busy, a_valid, a_meas, a_ovf, a_miss} !== 20'd0) begin
      n_err++; $display("FAIL rst_done: got %b, want all zero", {a_busy, a_valid, a_meas, a_ovf, a_miss});
    end
    #2;
    tick();
    rst = 1'b0;
    a_ready = 1'b1;
    exp_q.push_back(exp_t'{ovf: 1'b0, meas: 16'd5});
    measure_a(6);
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || a_valid !== 1'b1 || a_meas !== e.meas) begin
      n_err++; $display("FAIL rst_done_after: got valid=%b meas=%0d, want valid=1 meas=%0d", a_valid, a_meas, e.meas);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_saturate();
    test_rearm();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d pending entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
